// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1: merges four valid/ready channels onto one registered output
// stream. Round-robin arbitration starts at ptr. Each beat is tagged with its
// source channel (out_sel), so a downstream 1-to-4 demux can use the tag
// directly as its select.
module rr_mux_4to1 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         out_valid,
  input  logic         out_ready
);

  // Round-robin pointer: the highest-priority channel for the next grant.
  logic [1:0]   ptr;

  logic         ld;
  logic         any;
  logic [1:0]   g;
  logic [W-1:0] g_data;

  // The output register may load when it is empty or its beat drains this cycle.
  assign ld  = !out_valid || out_ready;
  assign any = |in_valid;

  // Pick the first valid channel in cyclic order ptr, ptr+1, ptr+2, ptr+3.
  // The scan runs from the farthest offset down, so the nearest valid one wins.
  always_comb begin
    logic [1:0] idx;
    g = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (in_valid[idx]) begin
        g = idx;
      end
    end
  end

  // Select the granted channel's data.
  always_comb begin
    g_data = '0;
    unique case (g)
      2'd0: g_data = in_data0;
      2'd1: g_data = in_data1;
      2'd2: g_data = in_data2;
      2'd3: g_data = in_data3;
      default: g_data = '0;
    endcase
  end

  // One-hot ready to the granted channel. It is gated by rst because the
  // register reads as empty while in reset, which would otherwise make ld high.
  always_comb begin
    in_ready = 4'b0000;
    if (ld && any && !rst) begin
      in_ready[g] = 1'b1;
    end
  end

  // Output register and pointer. On an idle load only out_valid changes, so
  // the pointer keeps its fairness position across idle gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (ld) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_sel   <= g;
        ptr       <= g + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_4to1.sv
// tb_rr_mux_4to1: directed vectors with hand-computed expectations.
module tb_rr_mux_4to1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int failures = 0;

  rr_mux_4to1 #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order under full contention from ptr=0.
  logic [1:0] cont_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] ch_data  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0] single   [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    rst = 1'b1;
    in_valid = 4'b0000;
    out_ready = 1'b0;
    in_data0 = 8'hA0; in_data1 = 8'hB1; in_data2 = 8'hC2; in_data3 = 8'hD3;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'b0000);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;

    // Full contention: grants rotate 0,1,2,3,0,1 with no bubbles.
    for (int k = 0; k < 6; k++) begin
      check("cont_in_ready", 32'(in_ready), 32'(4'b0001 << cont_sel[k]));
      tick();
      check("cont_out_valid", 32'(out_valid), 32'd1);
      check("cont_out_sel", 32'(out_sel), 32'(cont_sel[k]));
      check("cont_out_data", 32'(out_data), 32'(ch_data[cont_sel[k]]));
    end
    // ptr is now 2.

    // Backpressure: load ch1 with 0xA5, then stall three cycles.
    in_data1 = 8'hA5;
    in_valid = 4'b0010;
    #1;
    check("bp_load_ready", 32'(in_ready), 32'b0010);
    tick();
    check("bp_loaded_data", 32'(out_data), 32'hA5);
    check("bp_loaded_sel", 32'(out_sel), 32'd1);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'b0000);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hA5);
      check("bp_out_sel", 32'(out_sel), 32'd1);
    end
    in_data1 = 8'hB1;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0100);
    tick();
    check("bp_release_sel", 32'(out_sel), 32'd2);
    check("bp_release_data", 32'(out_data), 32'hC2);
    // ptr is now 3.

    // Pointer skip: ch3 before ch0.
    in_valid = 4'b1001;
    #1;
    check("skip_ready_a", 32'(in_ready), 32'b1000);
    tick();
    check("skip_sel_a", 32'(out_sel), 32'd3);
    check("skip_data_a", 32'(out_data), 32'hD3);
    #1;
    check("skip_ready_b", 32'(in_ready), 32'b0001);
    tick();
    check("skip_sel_b", 32'(out_sel), 32'd0);
    check("skip_data_b", 32'(out_data), 32'hA0);
    // ptr is now 1.

    // Idle drain: beat leaves, nothing enters, ptr stays at 1.
    in_valid = 4'b0000;
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_hold_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("idle_next_ready", 32'(in_ready), 32'b0010);
    tick();
    check("idle_next_sel", 32'(out_sel), 32'd1);
    check("idle_next_data", 32'(out_data), 32'hB1);

    // Single channel streaming on ch2.
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      in_data2 = single[k];
      #1;
      check("single_ready", 32'(in_ready), 32'b0100);
      tick();
      check("single_sel", 32'(out_sel), 32'd2);
      check("single_data", 32'(out_data), 32'(single[k]));
      check("single_valid", 32'(out_valid), 32'd1);
    end
    // ptr is now 3, and a beat is held.

    // Mid-cycle reset while a beat is held.
    in_data2 = 8'hC2;
    in_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sel", 32'(out_sel), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    check("midrst_in_ready", 32'(in_ready), 32'b0000);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("postrst_ready", 32'(in_ready), 32'b0001);
    tick();
    check("postrst_sel", 32'(out_sel), 32'd0);
    check("postrst_data", 32'(out_data), 32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_mux_4to1.md
Name: rr_mux_4to1

Overview:
Sequential 4-to-1 multiplexer and the collecting counterpart of our 1-to-4 demultiplexer. It merges four valid/ready input channels onto one registered output stream. Each output beat carries a 2-bit channel tag (out_sel), which a downstream demux uses directly as its select to redistribute the data. Arbitration is round-robin, so no channel can starve another.

Parameters:
W, 8, data width of every input channel and of out_data.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  asynchronous, active-high reset.
in_data0  input  W  channel 0 data.
in_data1  input  W  channel 1 data.
in_data2  input  W  channel 2 data.
in_data3  input  W  channel 3 data.
in_valid  input  4  bit i is high when channel i presents a beat.
in_ready  output  4  bit i is high when channel i's beat is accepted this cycle.
out_data  output  W  registered data of the held beat.
out_sel  output  2  index of the channel that supplied out_data.
out_valid  output  1  output register holds a beat.
out_ready  input  1  downstream accepts the held beat this cycle.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is 0 whenever out_valid=1 and out_ready=0; otherwise it follows the grant rule below.
- Internal state:
  - ptr: 2 bits, highest-priority channel for the next grant.
  - One output register: out_data, out_sel, out_valid.
- Load enable: ld = !out_valid || out_ready. The register is empty, or its beat drains this cycle.
- Grant (combinational):
  - g is the first i in the cyclic order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid[i]=1.
  - any = |in_valid.
  - in_ready[i] = ld && any && (i==g). At most one bit is high; it is never high for a non-valid channel.
  - in_ready may depend combinationally on in_valid and out_ready. No input or output is registered on the ready path.
- Clock edge with ld && any:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - ptr <= g+1 (mod 4, wraps 3 to 0).
- Clock edge with ld && !any: out_valid <= 0. ptr, out_data and out_sel hold their values.
- Clock edge with !ld (stall): all outputs and ptr hold. out_data and out_sel must be stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - An accepted input appears on the outputs 1 cycle later.
  - Sustained throughput is 1 beat per cycle when out_ready stays high, including drain and load in the same cycle.
- Simultaneous events:
  - The drain of the old beat and the load of a new beat in one cycle are both legal. No beat is lost or duplicated.
  - Unselected valid channels keep in_ready=0 and must hold their data (standard valid/ready rule; the block does not check it).
- Reset mid-operation: any held beat is discarded immediately, out_valid drops asynchronously, and ptr returns to 0. No in_ready is asserted while rst=1.
- Fairness: a channel whose in_valid stays continuously high is granted within 4 load opportunities.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_sel=0, out_data=0 and in_ready=0 immediately; after release, ptr=0 (verified by the next scenario's first grant being channel 0).
- Single channel: in_valid=4'b0100, in_data2 = 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 -> in_ready=4'b0100 each cycle; out_data 0x11, 0x22, 0x33 with out_sel=2, one cycle after each acceptance.
- Full contention: in_valid=4'b1111 held, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0,1 with out_valid continuously 1.
- Pointer skip: after a grant to ch2 (ptr=3), present in_valid=4'b1001 -> ch3 granted first, then ch0.
- Backpressure: out_valid=1 with out_data=0xA5, out_sel=1, hold out_ready=0 for 3 cycles while in_valid=4'b1111 -> out_data and out_sel stable, in_ready=0; on out_ready=1, the next beat (ch2) loads in the same cycle.
- Idle drain: one beat held, in_valid=0, out_ready=1 -> out_valid drops next cycle and ptr is unchanged (a later single valid channel is granted normally).
